// File: rtl/flex_pts_framer.sv
// Parallel-to-serial framer: one-deep holding register feeding a shift register, optional parity bit.
// Latency: a word accepted at edge E0 is loaded at E1 when idle, or back-to-back at the final strobe of the current frame.
// Backpressure: data_ready = ~hold_valid, with no bypass; the next word waits in the hold register while the current one shifts.
module flex_pts_framer #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b1,
  parameter int PARITY    = 0,
  parameter bit IDLE_VAL  = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                serial_out,
  output logic                busy,
  output logic                frame_done
);

  localparam int FRAME = NUM_BITS + ((PARITY != 0) ? 1 : 0);
  localparam int CW    = $clog2(FRAME + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME - 1);
  localparam logic [CW-1:0] CNT_SHLIM = CW'(NUM_BITS - 1);
  localparam logic [CW-1:0] CNT_PAR   = CW'(NUM_BITS);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] hold_q, hold_d;
  logic [NUM_BITS-1:0] sr_q, sr_d;
  logic                hold_vld_q, hold_vld_d;
  logic                par_q, par_d;
  logic                done_q, done_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic accept;
  logic frame_end;
  logic load;
  logic word_par;

  // Handshake and load qualifiers
  always_comb begin
    accept    = data_valid && !hold_vld_q;
    frame_end = (state_q == ST_SHIFT) && shift_enable && (cnt_q == CNT_LAST);
    load      = hold_vld_q && ((state_q == ST_IDLE) || frame_end);
    word_par  = ^hold_q;
  end

  // Next-state logic: hold register, shift register, counter, parity and state
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sr_d       = sr_q;
    par_d      = par_q;
    cnt_d      = cnt_q;
    done_d     = frame_end;

    if (accept) begin
      hold_d     = data_in;
      hold_vld_d = 1'b1;
    end

    if (load) begin
      sr_d       = hold_q;
      par_d      = (PARITY == 2) ? ~word_par : word_par;
      cnt_d      = '0;
      hold_vld_d = 1'b0;
      state_d    = ST_SHIFT;
    end else if (frame_end) begin
      // Last bit period over and nothing waiting: back to the idle line level
      state_d = ST_IDLE;
    end else if ((state_q == ST_SHIFT) && shift_enable) begin
      cnt_d = cnt_q + 1'b1;
      // Data bits shift only until the last one is at the output; the parity
      // period (if any) leaves the register alone
      if (cnt_q < CNT_SHLIM) begin
        if (SHIFT_MSB) begin
          sr_d = {sr_q[NUM_BITS-2:0], IDLE_VAL};
        end else begin
          sr_d = {IDLE_VAL, sr_q[NUM_BITS-1:1]};
        end
      end
    end
  end

  // State registers with asynchronous clear to the idle line level
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      sr_q       <= {NUM_BITS{IDLE_VAL}};
      par_q      <= IDLE_VAL;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      sr_q       <= sr_d;
      par_q      <= par_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  // Outputs depend only on registers; the line mux picks data bit or parity bit
  always_comb begin
    data_ready = !hold_vld_q;
    busy       = (state_q == ST_SHIFT);
    frame_done = done_q;
    serial_out = IDLE_VAL;
    if (state_q == ST_SHIFT) begin
      if (cnt_q < CNT_PAR) begin
        serial_out = SHIFT_MSB ? sr_q[NUM_BITS-1] : sr_q[0];
      end else begin
        serial_out = par_q;
      end
    end
  end

endmodule

// File: tb/tb_flex_pts_framer.sv
// Bench for flex_pts_framer: three instances (MSB/no parity, LSB/even, LSB/odd) share stimulus.
// Expected line bits are queued at accept time and checked at every cycle while busy.
// Strobe period, back-to-back framing, backpressure and mid-frame reset are exercised.
module tb_flex_pts_framer;

  logic       clk;
  logic       n_rst;
  logic       shift_enable;
  logic [7:0] data_in;
  logic       data_valid;
  logic [2:0] rdy, ser, bsy, dn;

  flex_pts_framer #(.NUM_BITS(8), .SHIFT_MSB(1'b1), .PARITY(0), .IDLE_VAL(1'b1)) u_msb (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .data_in(data_in),
    .data_valid(data_valid), .data_ready(rdy[0]), .serial_out(ser[0]), .busy(bsy[0]),
    .frame_done(dn[0]));

  flex_pts_framer #(.NUM_BITS(8), .SHIFT_MSB(1'b0), .PARITY(1), .IDLE_VAL(1'b1)) u_lsb_even (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .data_in(data_in),
    .data_valid(data_valid), .data_ready(rdy[1]), .serial_out(ser[1]), .busy(bsy[1]),
    .frame_done(dn[1]));

  flex_pts_framer #(.NUM_BITS(8), .SHIFT_MSB(1'b0), .PARITY(2), .IDLE_VAL(1'b1)) u_lsb_odd (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .data_in(data_in),
    .data_valid(data_valid), .data_ready(rdy[2]), .serial_out(ser[2]), .busy(bsy[2]),
    .frame_done(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         per;
    logic       pe;
    logic       po;
  } vec_t;

  vec_t       vecs[7];
  logic [1:0] expq[3][$];   // {last_bit_of_frame, bit}
  logic [2:0] exp_done;
  logic [2:0] bsy_prev;
  int         busy_cnt[3];
  int         rise_cnt[3];
  int         n_cmp;
  int         n_bad;
  int         se_per;
  int         se_ctr;
  logic       mon_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s serial_out[%0d]", tag, i), ser[i], 1);
      chk($sformatf("%s busy[%0d]", tag, i), bsy[i], 0);
      chk($sformatf("%s data_ready[%0d]", tag, i), rdy[i], 1);
      chk($sformatf("%s frame_done[%0d]", tag, i), dn[i], 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (bsy[i]) busy_cnt[i]++;
      if (bsy[i] && !bsy_prev[i]) rise_cnt[i]++;
      bsy_prev[i] = bsy[i];
    end
    se_ctr++;
    shift_enable = ((se_ctr % se_per) == 0);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      busy_cnt[i] = 0;
      rise_cnt[i] = 0;
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic po);
    for (int i = 0; i < 3; i++) begin
      int n;
      n = (i == 0) ? 8 : 9;
      for (int k = 0; k < n; k++) begin
        logic b;
        if (i == 0)      b = d[7-k];
        else if (k < 8)  b = d[k];
        else             b = (i == 1) ? pe : po;
        expq[i].push_back({(k == n - 1), b});
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    logic idle;
    idle = 1'b0;
    for (int k = 0; k < 400 && !idle; k++) begin
      step();
      idle = (bsy == 3'b000) && (expq[0].size() == 0) && (expq[1].size() == 0) &&
             (expq[2].size() == 0);
    end
    chk({tag, " finished within budget"}, idle, 1);
    step();
    step();
  endtask

  // Monitor: every bit period must show the queued bit; pop on each strobe
  always @(negedge clk) begin : mon
    logic [1:0] e;
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("frame_done[%0d]", i), dn[i], exp_done[i]);
        exp_done[i] = 1'b0;
        if (bsy[i]) begin
          if (expq[i].size() == 0) begin
            chk($sformatf("busy with nothing queued[%0d]", i), bsy[i], 0);
          end else begin
            e = expq[i][0];
            chk($sformatf("serial_out bit[%0d]", i), ser[i], e[0]);
            if (shift_enable) begin
              void'(expq[i].pop_front());
              exp_done[i] = e[1];
            end
          end
        end else begin
          chk($sformatf("idle line[%0d]", i), ser[i], 1);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    clear_counts();
    se_per = v.per;
    push_frame(v.data, v.pe, v.po);
    data_valid = 1'b1;
    data_in    = v.data;
    se_ctr     = v.per - 1;     // strobe lands on the load edge, must be ignored
    step();                     // E0: accept
    data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("after accept busy[%0d]", i), bsy[i], 0);
      chk($sformatf("after accept data_ready[%0d]", i), rdy[i], 0);
    end
    step();                     // E1: load
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("after load busy[%0d]", i), bsy[i], 1);
      chk($sformatf("after load data_ready[%0d]", i), rdy[i], 1);
    end
    wait_idle("vector");
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("busy cycles[%0d] word %0h per %0d", i, v.data, v.per), busy_cnt[i],
          ((i == 0) ? 8 : 9) * v.per);
      chk($sformatf("busy rises[%0d]", i), rise_cnt[i], 1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_rst = 1'b0;
    data_valid = 1'b0;
    data_in = 8'h00;
    shift_enable = 1'b0;
    se_per = 1;
    se_ctr = 0;
    mon_en = 1'b0;
    exp_done = '0;
    bsy_prev = '0;
    clear_counts();

    vecs[0] = '{8'hA5, 1, 1'b0, 1'b1};
    vecs[1] = '{8'h07, 1, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 4, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 2, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1, 1'b0, 1'b1};
    vecs[5] = '{8'h01, 3, 1'b1, 1'b0};
    vecs[6] = '{8'h6E, 1, 1'b1, 1'b0};

    #12;
    chk_idle_outputs("in reset");
    @(negedge clk);
    n_rst = 1'b1;
    step();
    step();
    mon_en = 1'b1;

    foreach (vecs[j]) run_vec(vecs[j]);

    // Back-to-back: second word waits in hold, third word is refused
    clear_counts();
    se_per = 1;
    push_frame(8'h3C, 1'b0, 1'b1);
    data_valid = 1'b1;
    data_in    = 8'h3C;
    step();                     // E0
    data_valid = 1'b0;
    step();                     // E1 load
    push_frame(8'hC3, 1'b0, 1'b1);
    data_valid = 1'b1;
    data_in    = 8'hC3;
    step();                     // E2 accept into hold
    data_in    = 8'hFF;         // not ready: must not be captured
    for (int i = 0; i < 3; i++) chk($sformatf("held data_ready[%0d]", i), rdy[i], 0);
    step();
    step();
    step();
    for (int i = 0; i < 3; i++) chk($sformatf("still held data_ready[%0d]", i), rdy[i], 0);
    data_valid = 1'b0;
    wait_idle("back-to-back");
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b busy cycles[%0d]", i), busy_cnt[i], (i == 0) ? 16 : 18);
      chk($sformatf("b2b busy rises[%0d]", i), rise_cnt[i], 1);
    end

    // Reset mid-frame
    push_frame(8'hA5, 1'b0, 1'b1);
    data_valid = 1'b1;
    data_in    = 8'hA5;
    step();
    data_valid = 1'b0;
    step();
    step();
    step();
    mon_en = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    chk_idle_outputs("mid-frame reset");
    for (int i = 0; i < 3; i++) expq[i].delete();
    exp_done = '0;
    @(negedge clk);
    n_rst = 1'b1;
    clear_counts();
    step();
    mon_en = 1'b1;
    for (int k = 0; k < 10; k++) step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post-reset busy cycles[%0d]", i), busy_cnt[i], 0);
      chk($sformatf("post-reset data_ready[%0d]", i), rdy[i], 1);
    end
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
